// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner with press/release debounce,
// calculator key-code encoding and a fixed-width key strobe.
module keypad_scan_encoder #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STROBE_LEN      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] value,
  output logic       key_strobe,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] STR_LAST  = LW'(STROBE_LEN - 1);

  typedef enum logic [2:0] {
    SCAN,
    PRESS_DB,
    STROBE,
    WAIT_REL,
    REL_DB
  } state_t;

  state_t        state;
  logic [3:0]    col_m;
  logic [3:0]    col_s;
  logic [1:0]    row;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] db_cnt;
  logic [LW-1:0] str_cnt;
  logic [1:0]    lat_col;
  logic [3:0]    lat_pat;

  logic [3:0]    col_lo;
  logic          one_low;
  logic [1:0]    low_idx;
  logic [1:0]    row_nxt;

  function automatic logic [3:0] row_drv(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  function automatic logic [4:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 5'd2;
      4'd1:    return 5'd3;
      4'd2:    return 5'd4;
      4'd3:    return 5'd11;
      4'd4:    return 5'd5;
      4'd5:    return 5'd6;
      4'd6:    return 5'd7;
      4'd7:    return 5'd12;
      4'd8:    return 5'd8;
      4'd9:    return 5'd9;
      4'd10:   return 5'd10;
      4'd11:   return 5'd13;
      4'd12:   return 5'd16;
      4'd13:   return 5'd1;
      4'd14:   return 5'd15;
      default: return 5'd14;
    endcase
  endfunction

  assign col_lo  = ~col_s;
  assign one_low = (|col_lo) && ~|(col_lo & (col_lo - 4'd1));
  assign row_nxt = row + 2'd1;

  always_comb begin
    low_idx = 2'd0;
    case (col_lo)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  // Columns are asynchronous pull-ups; idle value is all-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SCAN;
      row        <= 2'd0;
      row_out    <= 4'b1110;
      scan_cnt   <= '0;
      db_cnt     <= '0;
      str_cnt    <= '0;
      lat_col    <= 2'd0;
      lat_pat    <= 4'hF;
      value      <= 5'd0;
      key_strobe <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      unique case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (one_low) begin
              lat_col <= low_idx;
              lat_pat <= col_s;
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end else begin
              row     <= row_nxt;
              row_out <= row_drv(row_nxt);
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        PRESS_DB: begin
          if (col_s != lat_pat) begin
            db_cnt  <= '0;
            row     <= row_nxt;
            row_out <= row_drv(row_nxt);
            state   <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            db_cnt     <= '0;
            value      <= key_code({row, lat_col});
            key_strobe <= 1'b1;
            key_held   <= 1'b1;
            str_cnt    <= '0;
            state      <= STROBE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        STROBE: begin
          if (str_cnt == STR_LAST) begin
            key_strobe <= 1'b0;
            state      <= WAIT_REL;
          end else begin
            str_cnt <= str_cnt + 1'b1;
          end
        end
        WAIT_REL: begin
          if (col_s[lat_col]) begin
            db_cnt <= '0;
            state  <= REL_DB;
          end
        end
        REL_DB: begin
          if (!col_s[lat_col]) begin
            db_cnt <= '0;
            state  <= WAIT_REL;
          end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            key_held <= 1'b0;
            row      <= row_nxt;
            row_out  <= row_drv(row_nxt);
            state    <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Bench for keypad_scan_encoder: physical keypad model driving
// col_in from row_out, random press/bounce/release scenarios.
module tb_keypad_scan_encoder;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int SL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [4:0] value;
  logic       key_strobe;
  logic       key_held;

  logic [15:0] keys = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          strobes = 0;
  int          slen = 0;
  logic [4:0]  exp_code = 5'd0;
  bit          mon_en = 1'b0;

  keypad_scan_encoder #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CYCLES(DB),
    .STROBE_LEN(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_in(col_in),
    .row_out(row_out),
    .value(value),
    .key_strobe(key_strobe),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  function automatic logic [4:0] key_code(input int k);
    string m = "123+456-789*C0E/";
    byte   ch;
    ch = m[k];
    if (ch >= "0" && ch <= "9") return 5'(ch - "0" + 1);
    case (ch)
      "+":     return 5'd11;
      "-":     return 5'd12;
      "*":     return 5'd13;
      "/":     return 5'd14;
      "E":     return 5'd15;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic [3:0] exp_row(input int r);
    return 4'(~(1 << r));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (key_strobe) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (key_strobe) begin
        if (slen == 0) strobes++;
        slen++;
        chk("strobe_value", value, exp_code);
      end else if (slen != 0) begin
        chk("strobe_width", slen, SL);
        slen = 0;
      end
    end
  end

  initial begin
    int         k;
    int         k2;
    int         hold;
    int         base;
    int         r;
    int         c1;
    int         c2;
    bit         ok;
    logic [3:0] seen;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_row", row_out, 4'b1110);
    chk("rst_value", value, 0);
    chk("rst_strobe", key_strobe, 0);
    chk("rst_held", key_held, 0);

    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) @(negedge clk);
      chk("idle_scan_row", row_out, exp_row((c / SD) % 4));
      chk("idle_strobe", key_strobe, 0);
    end
    chk("idle_value", value, 0);

    // Key "6" steady from reset release: sampled at cycle 7.
    reset = 1'b1;
    @(negedge clk);
    keys[6]  = 1'b1;
    exp_code = key_code(6);
    mon_en   = 1'b1;
    reset    = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      if (c != 0) @(negedge clk);
      chk("six_strobe", key_strobe, (c >= 16 && c <= 18));
      if (c == 15) chk("six_value_pre", value, 0);
      if (c == 16) chk("six_value", value, 7);
      if (c >= 4) chk("six_row_frozen", row_out, 4'b1101);
      if (c >= 16) chk("six_held", key_held, 1);
    end
    keys = '0;
    repeat (10) @(negedge clk);
    chk("six_rel_held", key_held, 1);
    chk("six_rel_row", row_out, 4'b1101);
    @(negedge clk);
    chk("six_rel_drop", key_held, 0);
    chk("six_next_row", row_out, 4'b1011);
    repeat (10) @(negedge clk);

    for (int t = 0; t < 12; t++) begin
      k    = (t == 0) ? 13 : int'($urandom_range(15));
      hold = (t == 0) ? 200 : int'($urandom_range(20, 60));
      base = strobes;
      exp_code = key_code(k);
      for (int b = int'($urandom_range(3)); b > 0; b--) begin
        keys[k] = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        keys[k] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      keys[k] = 1'b1;
      wait_strobe(ok);
      chk("press_strobe_seen", ok, 1);
      keys[k] = 1'b0;
      @(negedge clk);
      keys[k] = 1'b1;
      k2 = int'($urandom_range(15));
      if (k2 != k) keys[k2] = 1'b1;
      repeat (hold) @(negedge clk);
      chk("hold_held", key_held, 1);
      chk("hold_row", row_out, exp_row(k / 4));
      chk("hold_one_strobe", strobes - base, 1);
      keys = '0;
      repeat ($urandom_range(2, 6)) @(negedge clk);
      keys[k] = 1'b1;
      repeat (4) @(negedge clk);
      keys[k] = 1'b0;
      repeat (10) @(negedge clk);
      chk("rel_held_early", key_held, 1);
      @(negedge clk);
      chk("rel_held_drop", key_held, 0);
      repeat ($urandom_range(5, 30)) @(negedge clk);
      chk("trial_strobes", strobes - base, 1);
      chk("trial_value", value, exp_code);
    end

    // Two keys in one row must never be accepted.
    for (int m = 0; m < 2; m++) begin
      keys = '0;
      if (m == 0) begin
        keys = 16'h0009;
      end else begin
        r  = int'($urandom_range(3));
        c1 = int'($urandom_range(3));
        c2 = (c1 + int'($urandom_range(1, 3))) % 4;
        keys[r*4+c1] = 1'b1;
        keys[r*4+c2] = 1'b1;
      end
      base = strobes;
      seen = '0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        seen = seen | ~row_out;
      end
      chk("multi_no_strobe", strobes - base, 0);
      chk("multi_value", value, exp_code);
      chk("multi_scan", seen, 4'hF);
    end
    keys = '0;
    repeat (20) @(negedge clk);

    // Reset in the second strobe cycle.
    mon_en = 1'b0;
    k = int'($urandom_range(15));
    keys[k] = 1'b1;
    exp_code = key_code(k);
    wait_strobe(ok);
    chk("rst_strobe_seen", ok, 1);
    chk("rst_strobe_value", value, exp_code);
    @(negedge clk);
    chk("rst_strobe2", key_strobe, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobe", key_strobe, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_value", value, 0);
    chk("mid_rst_row", row_out, 4'b1110);
    keys = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      chk("post_rst_row", row_out, exp_row((c / SD) % 4));
      chk("post_rst_strobe", key_strobe, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
